// File: rtl/demux_stream_1to2.sv
// ============================================================================
// demux_stream_1to2
//
// Purpose:
//   Routes a single valid/ready input stream to one of two output streams.
//   in_sel picks the destination branch for each word. Each branch buffers
//   up to two words in its own small FIFO, so a stalled branch never blocks
//   the other one. Words appear on the selected output one cycle after they
//   are accepted.
//
// Ports:
//   clk         - single clock, rising edge
//   rst         - asynchronous, active-high reset
//   in_valid    - upstream word valid
//   in_data     - upstream payload (DWIDTH bits)
//   in_sel      - destination: 0 = branch 0, 1 = branch 1
//   in_ready    - word is accepted this cycle (selected branch not full)
//   out0_valid  - branch 0 word valid
//   out0_data   - branch 0 payload
//   out0_ready  - branch 0 downstream ready
//   out1_valid  - branch 1 word valid
//   out1_data   - branch 1 payload
//   out1_ready  - branch 1 downstream ready
//   cnt0, cnt1  - 16-bit wrapping counts of completed output transfers
//                 (present only when DEMUX_STREAM_CNT_EN is defined)
//
// Compile option:
//   DEMUX_STREAM_CNT_EN - adds the cnt0/cnt1 transfer counters.
// ============================================================================
module demux_stream_1to2 #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_sel,
    output logic              in_ready,
    output logic              out0_valid,
    output logic [DWIDTH-1:0] out0_data,
    input  logic              out0_ready,
    output logic              out1_valid,
    output logic [DWIDTH-1:0] out1_data,
    input  logic              out1_ready
`ifdef DEMUX_STREAM_CNT_EN
    ,
    output logic [15:0]       cnt0,
    output logic [15:0]       cnt1
`endif
);

    // Per-branch views, index 0 = branch 0, index 1 = branch 1.
    logic [1:0]             sel_vec;
    logic [1:0]             out_ready_vec;
    logic [1:0]             valid_vec;
    logic [1:0]             full_vec;
    logic [1:0]             push;
    logic [1:0]             pop;
    logic [1:0][DWIDTH-1:0] head;
`ifdef DEMUX_STREAM_CNT_EN
    logic [1:0][15:0]       cnt_vec;
`endif

    assign sel_vec       = {in_sel, ~in_sel};
    assign out_ready_vec = {out1_ready, out0_ready};

    // Readiness depends only on the registered fullness of the selected
    // branch, never on the downstream readies, so no combinational path
    // exists from out*_ready to in_ready.
    assign in_ready = ~full_vec[in_sel];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_branch
            logic [DWIDTH-1:0] mem_reg [2];
            logic              rd_ptr_reg;
            logic              wr_ptr_reg;
            logic [1:0]        count_reg;

            // A full branch refuses a push even if it pops in the same
            // cycle; this keeps in_ready free of any out*_ready term.
            assign push[gi]      = in_valid & sel_vec[gi] & ~full_vec[gi];
            assign pop[gi]       = valid_vec[gi] & out_ready_vec[gi];
            assign valid_vec[gi] = (count_reg != 2'd0);
            assign full_vec[gi]  = (count_reg == 2'd2);
            assign head[gi]      = mem_reg[rd_ptr_reg];

            // Storage is cleared on reset so the outputs read zero while
            // reset is held and no stale word survives it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_reg[0] <= '0;
                    mem_reg[1] <= '0;
                    rd_ptr_reg <= 1'b0;
                    wr_ptr_reg <= 1'b0;
                    count_reg  <= 2'd0;
                end else begin
                    if (push[gi]) begin
                        mem_reg[wr_ptr_reg] <= in_data;
                        wr_ptr_reg          <= ~wr_ptr_reg;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= ~rd_ptr_reg;
                    end
                    case ({push[gi], pop[gi]})
                        2'b10:   count_reg <= count_reg + 2'd1;
                        2'b01:   count_reg <= count_reg - 2'd1;
                        default: count_reg <= count_reg;
                    endcase
                end
            end

`ifdef DEMUX_STREAM_CNT_EN
            logic [15:0] xfer_cnt_reg;

            // Natural 16-bit overflow gives the 0xFFFF -> 0x0000 wrap.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    xfer_cnt_reg <= 16'd0;
                end else if (pop[gi]) begin
                    xfer_cnt_reg <= xfer_cnt_reg + 16'd1;
                end
            end

            assign cnt_vec[gi] = xfer_cnt_reg;
`endif
        end
    endgenerate

    assign out0_valid = valid_vec[0];
    assign out0_data  = head[0];
    assign out1_valid = valid_vec[1];
    assign out1_data  = head[1];

`ifdef DEMUX_STREAM_CNT_EN
    assign cnt0 = cnt_vec[0];
    assign cnt1 = cnt_vec[1];
`endif

endmodule

// File: tb/tb_demux_stream_1to2.sv
module tb_demux_stream_1to2;

    localparam int DWIDTH = 32;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [DWIDTH-1:0] in_data;
    logic              in_sel;
    logic              in_ready;
    logic              out0_valid;
    logic [DWIDTH-1:0] out0_data;
    logic              out0_ready;
    logic              out1_valid;
    logic [DWIDTH-1:0] out1_data;
    logic              out1_ready;
`ifdef DEMUX_STREAM_CNT_EN
    logic [15:0]       cnt0;
    logic [15:0]       cnt1;
`endif

    demux_stream_1to2 #(.DWIDTH(DWIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_ready   (in_ready),
        .out0_valid (out0_valid),
        .out0_data  (out0_data),
        .out0_ready (out0_ready),
        .out1_valid (out1_valid),
        .out1_data  (out1_data),
        .out1_ready (out1_ready)
`ifdef DEMUX_STREAM_CNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DWIDTH-1:0] exp0 [$];
    logic [DWIDTH-1:0] exp1 [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // One input cycle: drive after a rising edge, check in_ready at the
    // falling edge against the hand-predicted value, record the word in the
    // scoreboard if it is predicted to be accepted, then step past the edge.
    task automatic drive(input logic v, input logic s, input logic [DWIDTH-1:0] d,
                         input logic exp_ready);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        @(negedge clk);
        check($sformatf("in_ready sel=%0d data=%h", s, d), {63'd0, in_ready}, {63'd0, exp_ready});
        if (v && exp_ready) begin
            if (s) exp1.push_back(d);
            else   exp0.push_back(d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every output transfer is matched against its branch queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out0_valid && out0_ready) begin
                    if (exp0.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL out0_unexpected: got %h, expected no word", out0_data);
                    end else begin
                        check("out0_data", {32'd0, out0_data}, {32'd0, exp0.pop_front()});
                    end
                end
                if (out1_valid && out1_ready) begin
                    if (exp1.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL out1_unexpected: got %h, expected no word", out1_data);
                    end else begin
                        check("out1_data", {32'd0, out1_data}, {32'd0, exp1.pop_front()});
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = '0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        idle(2);

        // Reset state
        check("rst out0_valid", {63'd0, out0_valid}, 64'd0);
        check("rst out1_valid", {63'd0, out1_valid}, 64'd0);
        check("rst out0_data", {32'd0, out0_data}, 64'd0);
        check("rst out1_data", {32'd0, out1_data}, 64'd0);
        check("rst in_ready", {63'd0, in_ready}, 64'd1);
`ifdef DEMUX_STREAM_CNT_EN
        check("rst cnt0", {48'd0, cnt0}, 64'd0);
        check("rst cnt1", {48'd0, cnt1}, 64'd0);
`endif
        rst = 1'b0;

        // Routing to each branch, one-cycle latency, accepted on first edge
        drive(1'b1, 1'b0, 32'hA5A5A5A5, 1'b1);
        check("lat out0_valid", {63'd0, out0_valid}, 64'd1);
        check("lat out0_data", {32'd0, out0_data}, {32'd0, 32'hA5A5A5A5});
        check("lat out1_valid idle", {63'd0, out1_valid}, 64'd0);
        drive(1'b1, 1'b1, 32'h5A5A5A5A, 1'b1);
        check("lat out1_valid", {63'd0, out1_valid}, 64'd1);
        check("lat out1_data", {32'd0, out1_data}, {32'd0, 32'h5A5A5A5A});
        check("lat out0_valid drained", {63'd0, out0_valid}, 64'd0);
        idle(2);

        // Branch 0 stalled: two words fit, third refused, head stable
        out0_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h00000011, 1'b1);
        drive(1'b1, 1'b0, 32'h00000022, 1'b1);
        drive(1'b1, 1'b0, 32'h00000033, 1'b0);
        check("stall out0_data", {32'd0, out0_data}, {32'd0, 32'h00000011});
        check("stall out0_valid", {63'd0, out0_valid}, 64'd1);
        // in_ready follows in_sel even with in_valid low
        in_sel = 1'b0;
        #1 check("idle sel0 in_ready", {63'd0, in_ready}, 64'd0);
        in_sel = 1'b1;
        #1 check("idle sel1 in_ready", {63'd0, in_ready}, 64'd1);

        // Branch 1 flows every cycle while branch 0 is full
        drive(1'b1, 1'b1, 32'hB0000001, 1'b1);
        drive(1'b1, 1'b1, 32'hB0000002, 1'b1);
        drive(1'b1, 1'b1, 32'hB0000003, 1'b1);
        check("stall out0_data held", {32'd0, out0_data}, {32'd0, 32'h00000011});
        out0_ready = 1'b1;
        idle(4);
        check("drain out0_valid", {63'd0, out0_valid}, 64'd0);

        // Branch 1 at count 1 with push and pop every cycle
        out1_ready = 1'b0;
        drive(1'b1, 1'b1, 32'hC0000000, 1'b1);
        out1_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 1'b1, 32'hC0000000 + i, 1'b1);
            check($sformatf("pp out1_valid %0d", i), {63'd0, out1_valid}, 64'd1);
            check($sformatf("pp out1_data %0d", i), {32'd0, out1_data}, {32'd0, 32'hC0000000 + i});
        end
        idle(3);

        // Reset mid-stream with both branches full
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drive(1'b1, 1'b0, 32'hE0000000, 1'b1);
        drive(1'b1, 1'b0, 32'hE0000001, 1'b1);
        drive(1'b1, 1'b1, 32'hF0000000, 1'b1);
        drive(1'b1, 1'b1, 32'hF0000001, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mid rst out0_valid", {63'd0, out0_valid}, 64'd0);
        check("mid rst out1_valid", {63'd0, out1_valid}, 64'd0);
        check("mid rst out0_data", {32'd0, out0_data}, 64'd0);
        check("mid rst out1_data", {32'd0, out1_data}, 64'd0);
        check("mid rst in_ready", {63'd0, in_ready}, 64'd1);
`ifdef DEMUX_STREAM_CNT_EN
        check("mid rst cnt0", {48'd0, cnt0}, 64'd0);
        check("mid rst cnt1", {48'd0, cnt1}, 64'd0);
`endif
        exp0.delete();
        exp1.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;

`ifdef DEMUX_STREAM_CNT_EN
        // Counter wrap: 65537 transfers on branch 0
        for (int i = 0; i < 65537; i++) begin
            drive(1'b1, 1'b0, i, 1'b1);
        end
        idle(3);
        check("wrap cnt0", {48'd0, cnt0}, 64'h1);
        check("wrap cnt1", {48'd0, cnt1}, 64'h0);
`endif

        // First word after reset goes through cleanly
        drive(1'b1, 1'b0, 32'hD00DF00D, 1'b1);
        check("post rst out0_data", {32'd0, out0_data}, {32'd0, 32'hD00DF00D});
        idle(3);

        check("final exp0 empty", 64'(exp0.size()), 64'd0);
        check("final exp1 empty", 64'(exp1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_stream_1to2.md
DEMUX_STREAM_1TO2 -- requirements
Module: demux_stream_1to2

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, which sets the payload width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-005 The block SHALL have port in_data, input, DWIDTH bits: the upstream payload.
REQ-006 The block SHALL have port in_sel, input, 1 bit: destination select, 0 for branch 0 and 1 for branch 1.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the word this cycle.
REQ-008 The block SHALL have ports out0_valid (output, 1 bit), out0_data (output, DWIDTH bits) and out0_ready (input, 1 bit), forming the branch 0 stream.
REQ-009 The block SHALL have ports out1_valid (output, 1 bit), out1_data (output, DWIDTH bits) and out1_ready (input, 1 bit), forming the branch 1 stream.

Function
REQ-010 A transfer on any stream SHALL occur only in a cycle where valid and ready are both 1 at the rising clk edge.
REQ-011 Each branch SHALL contain a 2-entry FIFO: two DWIDTH data registers, a 1-bit read pointer, a 1-bit write pointer and a 2-bit count (0..2).
REQ-012 in_ready SHALL equal 1 when the count of the branch selected by in_sel is less than 2; in_ready SHALL NOT depend combinationally on out0_ready or out1_ready.
REQ-013 When the input transfers, in_data SHALL be written into the selected branch FIFO only, and the unselected branch SHALL remain unchanged.
REQ-014 outN_valid SHALL equal (countN != 0), and outN_data SHALL equal the entry at the read pointer of branch N.
REQ-015 Latency SHALL be 1 cycle: a word accepted at edge k SHALL appear on outN_valid/outN_data after edge k.
REQ-016 Throughput SHALL be one word per cycle per branch while the downstream ready is held at 1.
REQ-017 Simultaneous push and pop on the same branch SHALL leave the count unchanged and advance both pointers.
REQ-018 When a branch count is 2, no push SHALL occur on that branch; a pop in the same cycle SHALL NOT enable a push in that cycle.
REQ-019 Pointers SHALL wrap from 1 to 0.
REQ-020 Words within a branch SHALL leave in acceptance order; no ordering SHALL be guaranteed between the two branches.
REQ-021 outN_data SHALL hold its value while outN_valid=1 and outN_ready=0.
REQ-022 in_data and in_sel SHALL be ignored when in_valid=0, and in_ready SHALL still reflect REQ-012.
REQ-023 A stall on one branch SHALL NOT block pushes to, or pops from, the other branch.

Reset
REQ-024 On rst=1, both counts and all pointers SHALL clear to 0 immediately, without waiting for a clk edge.
REQ-025 During reset, out0_valid=0 and out1_valid=0, out0_data=0 and out1_data=0, and in_ready=1.
REQ-026 Any words buffered when reset is asserted SHALL be discarded, with no partial state retained.
REQ-027 The first transfer after reset SHALL be accepted on the first rising clk edge at which rst=0.

Configuration
REQ-028 The compile macro DEMUX_STREAM_CNT_EN SHALL control the transfer counters.
REQ-029 When DEMUX_STREAM_CNT_EN is defined, the block SHALL add output ports cnt0 and cnt1, each 16 bits, counting completed transfers on out0 and out1 respectively.
REQ-030 When DEMUX_STREAM_CNT_EN is defined, the counters SHALL wrap from 0xFFFF to 0x0000 and SHALL reset to 0 under rst.
REQ-031 When DEMUX_STREAM_CNT_EN is undefined, the ports cnt0/cnt1 and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Scenario: rst=1 mid-stream while both branches hold 2 words -> out0_valid=0 and out1_valid=0 immediately, in_ready=1, and cnt0=cnt1=0 when counters are enabled.
REQ-033 Scenario: push 0xA5A5A5A5 with sel=0, then 0x5A5A5A5A with sel=1, with both readies at 1 -> each word appears on its own branch one cycle later, and no word appears on the other branch.
REQ-034 Scenario: out0_ready=0 while 3 words are sent with sel=0 -> first two accepted, in_ready=0 on the third, out0_data stable at the first word; releasing out0_ready drains the words in order.
REQ-035 Scenario: out0 full with in_sel switched to 1 -> in_ready=1 and branch 1 accepts every cycle with out1_ready=1.
REQ-036 Scenario: branch 1 count=1 with simultaneous push and pop for 10 cycles -> count stays 1, data order preserved, pointers wrap correctly.
REQ-037 Scenario: counters enabled, 65537 transfers on out0 -> cnt0=0x0001 and cnt1 unchanged.
